ro_puf_array: RTL and testbench

Parametrised ring-oscillator PUF controller, the next generation of the fixed 8-bit RO_PUF. Takes a challenge and selects oscillator pairs from an array of N_RO externally instantiated ROs. For each pair it counts synchronised rising edges over a fixed window, compares the two counts, and assembles a RESP_W-bit response. An optional majority-vote mode repeats each measurement for stability; DONE and RESPONSE drive the LED/seven-segment display path.

---
 rtl/ro_puf_array_pkg.sv | 21 ++
 rtl/ro_puf_array_if.sv | 28 ++
 rtl/ro_puf_array_edge_counter.sv | 42 ++++
 rtl/ro_puf_array.sv | 194 +++++++++++++++++++
 tb/tb_ro_puf_array.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ro_puf_array_pkg.sv
// Shared types and helpers for the ring-oscillator PUF controller.
package ro_puf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_MEASURE,
      ST_COMPARE,
      ST_FINISH
   } puf_state_t;

   // Oscillator index of one member of a pair: (base + bit + offset) wrapped to the array size.
   // The array size is a power of two, so the modulo reduces to dropping high bits.
   function automatic int unsigned pair_index(input int unsigned base,
                                              input int unsigned bit_idx,
                                              input int unsigned offset,
                                              input int unsigned n_ro);
      return (base + bit_idx + offset) % n_ro;
   endfunction

endpackage

// File: rtl/ro_puf_array_if.sv
// Control/status bundle between the PUF controller and its user, plus the
// raw oscillator inputs and their enables.
interface ro_puf_array_if #(
   parameter int N_RO   = 16,
   parameter int CHAL_W = 4,
   parameter int RESP_W = 8
);

   logic              start;
   logic [CHAL_W-1:0] challenge;
   logic              vote_en;
   logic [N_RO-1:0]   ro_in;
   logic [N_RO-1:0]   ro_en;
   logic [RESP_W-1:0] response;
   logic              busy;
   logic              done;

   modport master (
      output start, challenge, vote_en, ro_in,
      input  ro_en, response, busy, done
   );

   modport slave (
      input  start, challenge, vote_en, ro_in,
      output ro_en, response, busy, done
   );

endinterface

// File: rtl/ro_puf_array_edge_counter.sv
// One measurement channel: brings an asynchronous oscillator into the clock
// domain, detects its rising edges and counts them without wrapping.
module ro_edge_counter #(
   parameter int CNT_W = 10
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             ro_in,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0] sync_q;
   logic       sync_d;
   logic       rise;

   // Two-flop synchroniser followed by a delayed copy for edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         sync_d <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], ro_in};
         sync_d <= sync_q[1];
      end
   end

   assign rise = sync_q[1] & ~sync_d;

   // Saturating edge counter; clear wins over counting.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable && rise && (count != CNT_MAX)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/ro_puf_array.sv
// Ring-oscillator PUF controller. For each response bit it selects an
// oscillator pair derived from the latched challenge, counts edges of both
// over a fixed window after a quiet settle gap, and records which one was
// faster. In vote mode each bit is the majority of several measurements.
module ro_puf_array
   import ro_puf_pkg::*;
#(
   parameter int N_RO   = 16,
   parameter int CHAL_W = 4,
   parameter int RESP_W = 8,
   parameter int CNT_W  = 10,
   parameter int WINDOW = 256,
   parameter int SETTLE = 4,
   parameter int VOTES  = 3
)(
   input logic           clk,
   input logic           reset,
   ro_puf_array_if.slave puf_bus
);

   localparam int HALF    = N_RO / 2;
   localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
   localparam int TMR_W   = $clog2(TMR_MAX);
   localparam int BIT_W   = (RESP_W > 1) ? $clog2(RESP_W) : 1;
   localparam int VOTE_W  = $clog2(VOTES + 1);

   puf_state_t        state;
   puf_state_t        next_state;
   logic [TMR_W-1:0]  timer;
   logic [CHAL_W-1:0] challenge_q;
   logic              vote_q;
   logic [BIT_W-1:0]  bit_idx;
   logic [VOTE_W-1:0] meas_idx;
   logic [VOTE_W-1:0] tally;
   logic [VOTE_W-1:0] tally_next;
   logic [VOTE_W-1:0] meas_total;
   logic [CHAL_W-1:0] a_idx;
   logic [CHAL_W-1:0] b_idx;
   logic [CNT_W-1:0]  cnt_a;
   logic [CNT_W-1:0]  cnt_b;
   logic              cnt_clear;
   logic              cnt_enable;
   logic              vote_bit;
   logic              last_meas;
   logic              last_bit;
   logic              settle_end;
   logic              window_end;
   logic [N_RO-1:0]   ro_en_c;
   logic [RESP_W-1:0] response_q;
   logic              busy_q;
   logic              done_q;

   // Pair selection: the second member sits half the array away from the first.
   assign a_idx = CHAL_W'(pair_index(32'(challenge_q), 32'(bit_idx), 32'd0, 32'(N_RO)));
   assign b_idx = CHAL_W'(pair_index(32'(challenge_q), 32'(bit_idx), 32'(HALF), 32'(N_RO)));

   assign cnt_clear  = (state == ST_SETTLE);
   assign cnt_enable = (state == ST_MEASURE);

   ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
      .clk    (clk),
      .reset  (reset),
      .ro_in  (puf_bus.ro_in[a_idx]),
      .clear  (cnt_clear),
      .enable (cnt_enable),
      .count  (cnt_a)
   );

   ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
      .clk    (clk),
      .reset  (reset),
      .ro_in  (puf_bus.ro_in[b_idx]),
      .clear  (cnt_clear),
      .enable (cnt_enable),
      .count  (cnt_b)
   );

   // A tie counts as a 0 vote, so two dead oscillators always give 0.
   assign vote_bit   = (cnt_a > cnt_b);
   assign tally_next = tally + VOTE_W'(vote_bit);
   assign meas_total = vote_q ? VOTE_W'(VOTES) : VOTE_W'(1);
   assign last_meas  = (meas_idx == (meas_total - VOTE_W'(1)));
   assign last_bit   = (bit_idx == BIT_W'(RESP_W - 1));
   assign settle_end = (timer == TMR_W'(SETTLE - 1));
   assign window_end = (timer == TMR_W'(WINDOW - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode and oscillator enables; only the measured pair runs.
   always_comb begin
      next_state = state;
      ro_en_c    = '0;
      unique case (state)
         ST_IDLE: begin
            if (puf_bus.start) begin
               next_state = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (settle_end) begin
               next_state = ST_MEASURE;
            end
         end
         ST_MEASURE: begin
            ro_en_c[a_idx] = 1'b1;
            ro_en_c[b_idx] = 1'b1;
            if (window_end) begin
               next_state = ST_COMPARE;
            end
         end
         ST_COMPARE: begin
            if (!last_meas || !last_bit) begin
               next_state = ST_SETTLE;
            end else begin
               next_state = ST_FINISH;
            end
         end
         ST_FINISH: begin
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Phase timer, run bookkeeping, vote tally and the registered result outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         timer       <= '0;
         challenge_q <= '0;
         vote_q      <= 1'b0;
         bit_idx     <= '0;
         meas_idx    <= '0;
         tally       <= '0;
         response_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         if ((state != next_state) || (state == ST_IDLE)) begin
            timer <= '0;
         end else begin
            timer <= timer + 1'b1;
         end

         unique case (state)
            ST_IDLE: begin
               if (puf_bus.start) begin
                  challenge_q <= puf_bus.challenge;
                  vote_q      <= puf_bus.vote_en;
                  bit_idx     <= '0;
                  meas_idx    <= '0;
                  tally       <= '0;
                  response_q  <= '0;
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
               end
            end
            ST_COMPARE: begin
               if (!last_meas) begin
                  meas_idx <= meas_idx + 1'b1;
                  tally    <= tally_next;
               end else begin
                  response_q[bit_idx] <= (tally_next > (meas_total >> 1));
                  meas_idx            <= '0;
                  tally               <= '0;
                  if (!last_bit) begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
            end
            ST_FINISH: begin
               done_q <= 1'b1;
               busy_q <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   assign puf_bus.ro_en    = ro_en_c;
   assign puf_bus.response = response_q;
   assign puf_bus.busy     = busy_q;
   assign puf_bus.done     = done_q;

endmodule

// File: tb/tb_ro_puf_array.sv
// Bench for ro_puf_array: synthetic oscillators of known frequency, a
// frequency-based response model and a scoreboard of expected results.
// A second instance with a 6-bit counter exercises saturation.
module tb_ro_puf_array;

   localparam int N_RO        = 16;
   localparam int CHAL_W      = 4;
   localparam int RESP_W      = 8;
   localparam int WINDOW      = 256;
   localparam int SETTLE      = 4;
   localparam int MODE_NORMAL = 0;
   localparam int MODE_STUCK  = 1;
   localparam int MODE_VOTE   = 2;
   localparam int TIMEOUT     = 20000;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   // Free-running system clock.
   always #5 clk = ~clk;

   ro_puf_array_if #(.N_RO(N_RO), .CHAL_W(CHAL_W), .RESP_W(RESP_W)) bus ();
   ro_puf_array_if #(.N_RO(N_RO), .CHAL_W(CHAL_W), .RESP_W(RESP_W)) bus_sat ();

   assign bus_sat.start     = bus.start;
   assign bus_sat.challenge = bus.challenge;
   assign bus_sat.vote_en   = bus.vote_en;
   assign bus_sat.ro_in     = bus.ro_in;

   ro_puf_array dut (
      .clk     (clk),
      .reset   (reset),
      .puf_bus (bus)
   );

   ro_puf_array #(.CNT_W(6)) dut_sat (
      .clk     (clk),
      .reset   (reset),
      .puf_bus (bus_sat)
   );

   typedef struct {
      logic [7:0]  resp;
      logic [7:0]  resp_sat;
      int          lat;
      logic [15:0] probe_en;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;
   int          mode  = MODE_NORMAL;
   logic [2:0]  pat   = 3'b000;
   int          run_id = 0;

   logic [15:0] wave     = '0;
   int          hc[16]   = '{default: 0};
   logic        slow0    = 1'b0;
   logic        w8       = 1'b0;
   int          slow_cnt = 0;
   int          w8_cnt   = 0;
   int          win      = 0;
   int          seen_run = 0;
   logic [15:0] en_prev  = '0;
   logic [15:0] ro;

   // Oscillator farm: RO k toggles every k+1 cycles; in vote mode RO 0 is
   // fast or slow per measurement window and RO 8 sits in between.
   always @(negedge clk) begin
      if (run_id != seen_run) begin
         seen_run = run_id;
         win      = 0;
      end else if ((en_prev != '0) && (bus.ro_en == '0)) begin
         win++;
      end
      en_prev = bus.ro_en;
      for (int k = 0; k < 16; k++) begin
         if (hc[k] >= k) begin
            wave[k] = ~wave[k];
            hc[k]   = 0;
         end else begin
            hc[k]++;
         end
      end
      if (slow_cnt >= 19) begin
         slow0    = ~slow0;
         slow_cnt = 0;
      end else begin
         slow_cnt++;
      end
      if (w8_cnt >= 4) begin
         w8     = ~w8;
         w8_cnt = 0;
      end else begin
         w8_cnt++;
      end
      ro = wave;
      if (mode == MODE_STUCK) begin
         ro = '0;
      end else if (mode == MODE_VOTE) begin
         ro[0] = ((win < 3) && pat[win]) ? wave[0] : slow0;
         ro[8] = w8;
      end
      bus.ro_in = ro;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
      end
   endtask

   // Expected edges in one window for oscillator k toggling every h cycles.
   function automatic int modelCount(int k, int m, logic [2:0] p, int meas, int cmax);
      int h;
      int n;
      if (m == MODE_STUCK) return 0;
      h = k + 1;
      if (m == MODE_VOTE) begin
         if (k == 0) h = p[meas] ? 1 : 20;
         else if (k == 8) h = 5;
      end
      n = WINDOW / (2 * h);
      return (n > cmax) ? cmax : n;
   endfunction

   function automatic logic [7:0] modelResp(int c, logic v, int m, logic [2:0] p, int cmax);
      logic [7:0] r;
      int         nm;
      r  = '0;
      nm = v ? 3 : 1;
      for (int i = 0; i < RESP_W; i++) begin
         int a;
         int b;
         int votes;
         a     = (c + i) % N_RO;
         b     = (c + i + N_RO / 2) % N_RO;
         votes = 0;
         for (int j = 0; j < nm; j++) begin
            if (modelCount(a, m, p, j, cmax) > modelCount(b, m, p, j, cmax)) votes++;
         end
         r[i] = (votes > nm / 2);
      end
      return r;
   endfunction

   task automatic startRun(input logic [3:0] c, input logic v, input int m, input logic [2:0] p);
      @(negedge clk);
      mode          = m;
      pat           = p;
      run_id++;
      bus.challenge = c;
      bus.vote_en   = v;
      bus.start     = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      checkOutput("busy_on_start", 32'(bus.busy), 32'd1);
      checkOutput("done_cleared", 32'(bus.done), 32'd0);
      checkOutput("resp_cleared", 32'(bus.response), 32'd0);
   endtask

   task automatic applyStimulus(input logic [3:0] c, input logic v, input int m, input logic [2:0] p);
      exp_t e;
      int   ci;
      ci         = int'(c);
      e.resp     = modelResp(ci, v, m, p, 1023);
      e.resp_sat = modelResp(ci, v, m, p, 63);
      e.lat      = RESP_W * (v ? 3 : 1) * (SETTLE + WINDOW + 1) + 1;
      e.probe_en = 16'(1 << ci) | 16'(1 << ((ci + N_RO / 2) % N_RO));
      sb.push_back(e);
      startRun(c, v, m, p);
   endtask

   task automatic collectResult(input int inject_cyc);
      exp_t e;
      int   cyc;
      cyc = 0;
      while ((bus.done !== 1'b1) && (cyc < TIMEOUT)) begin
         @(posedge clk);
         #1;
         cyc++;
         bus.start = 1'b0;
         if (cyc == 2) checkOutput("ro_en_settle", 32'(bus.ro_en), 32'd0);
         if (cyc == 10) checkOutput("ro_en_measure", 32'(bus.ro_en), 32'(sb[0].probe_en));
         if (cyc == inject_cyc) begin
            bus.challenge = bus.challenge ^ 4'h8;
            bus.start     = 1'b1;
         end
      end
      if (bus.done !== 1'b1) checkOutput("done_timeout", 32'(bus.done), 32'd1);
      e = sb.pop_front();
      checkOutput("latency", 32'(cyc), 32'(e.lat));
      checkOutput("response", 32'(bus.response), 32'(e.resp));
      checkOutput("response_sat", 32'(bus_sat.response), 32'(e.resp_sat));
      checkOutput("done_sat", 32'(bus_sat.done), 32'd1);
      checkOutput("busy_after_done", 32'(bus.busy), 32'd0);
   endtask

   // Test sequence.
   initial begin
      bus.start     = 1'b0;
      bus.challenge = '0;
      bus.vote_en   = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      checkOutput("reset_ro_en", 32'(bus.ro_en), 32'd0);
      checkOutput("reset_busy", 32'(bus.busy), 32'd0);
      checkOutput("reset_done", 32'(bus.done), 32'd0);
      checkOutput("reset_response", 32'(bus.response), 32'd0);

      applyStimulus(4'd0, 1'b0, MODE_NORMAL, 3'b000);
      collectResult(-1);
      applyStimulus(4'd8, 1'b0, MODE_NORMAL, 3'b000);
      collectResult(-1);
      applyStimulus(4'd4, 1'b0, MODE_NORMAL, 3'b000);
      collectResult(-1);
      applyStimulus(4'd5, 1'b0, MODE_STUCK, 3'b000);
      collectResult(-1);
      applyStimulus(4'd0, 1'b1, MODE_VOTE, 3'b101);
      collectResult(-1);
      applyStimulus(4'd0, 1'b1, MODE_VOTE, 3'b010);
      collectResult(-1);

      startRun(4'd4, 1'b0, MODE_NORMAL, 3'b000);
      repeat (100) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("abort_ro_en", 32'(bus.ro_en), 32'd0);
      checkOutput("abort_busy", 32'(bus.busy), 32'd0);
      checkOutput("abort_done", 32'(bus.done), 32'd0);
      checkOutput("abort_response", 32'(bus.response), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      applyStimulus(4'd4, 1'b0, MODE_NORMAL, 3'b000);
      collectResult(-1);
      applyStimulus(4'd0, 1'b0, MODE_NORMAL, 3'b000);
      collectResult(500);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
